noc_resp_to_ld_adapter: RTL and testbench

Return path of the fifo-controller load unit. Accepts load-response messages from the P-Mesh NoC and matches each one, by MSHR ID, against a table of outstanding requests. The table is filled by the request-side issue tap. Each matched response is aligned and masked to the requested size, then handed to the load unit through a 2-entry registered response queue. The block also reports the outstanding-request count, for fencing and drain logic.

---
 rtl/noc_resp_to_ld_adapter.sv | 150 +++++++++++++++
 tb/tb_noc_resp_to_ld_adapter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_resp_to_ld_adapter.sv
// Load-response return path: matches NoC responses to outstanding MSHR entries,
// aligns/masks the data to the request size and queues it for the load unit.
module noc_resp_to_ld_adapter #(
   parameter int NUM_ENTRIES = 8,
   parameter int MSHRID_W    = 8,
   parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_fire,
   input  logic [MSHRID_W-1:0] issue_mshrid,
   input  logic [3:0]          issue_addr_lo,
   input  logic [2:0]          issue_size,
   input  logic                noc_resp_valid,
   output logic                noc_resp_ready,
   input  logic [MSHRID_W-1:0] noc_resp_mshrid,
   input  logic [63:0]         noc_resp_data_0,
   input  logic [63:0]         noc_resp_data_1,
   output logic                ld_resp_valid,
   input  logic                ld_resp_ready,
   output logic [MSHRID_W-1:0] ld_resp_mshrid,
   output logic [127:0]        ld_resp_data,
   output logic [CNT_W-1:0]    outstanding,
   output logic                err
);
   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   logic [NUM_ENTRIES-1:0] vld_reg, vld_next;
   logic [NUM_ENTRIES-1:0] alloc_sel, free_sel;
   logic [3:0]             addr_reg [NUM_ENTRIES];
   logic [2:0]             size_reg [NUM_ENTRIES];

   logic                issue_in_range, resp_in_range;
   logic [IDX_W-1:0]    issue_idx, resp_idx;
   logic                resp_hit, accept, push, pop;
   logic [3:0]          old_addr;
   logic [2:0]          old_size;
   logic                bad_size;
   logic [127:0]        raw, shifted, aligned;
   logic                err_reg;
   logic [CNT_W-1:0]    cnt_next;

   logic                head_vld_reg, tail_vld_reg;
   logic [MSHRID_W-1:0] head_id_reg, tail_id_reg;
   logic [127:0]        head_data_reg, tail_data_reg;

   assign issue_in_range = 32'(issue_mshrid) < NUM_ENTRIES;
   assign resp_in_range  = 32'(noc_resp_mshrid) < NUM_ENTRIES;
   assign issue_idx      = issue_mshrid[IDX_W-1:0];
   assign resp_idx       = noc_resp_mshrid[IDX_W-1:0];

   // Same-cycle alloc/hit reads the old entry contents, which the registered table gives for free.
   assign resp_hit = resp_in_range & vld_reg[resp_idx];
   assign old_addr = addr_reg[resp_idx];
   assign old_size = size_reg[resp_idx];

   assign noc_resp_ready = rst | ~tail_vld_reg | ld_resp_ready;
   assign accept         = noc_resp_valid & noc_resp_ready;
   assign push           = accept & resp_hit;
   assign pop            = head_vld_reg & ld_resp_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
         assign alloc_sel[gi] = issue_fire & issue_in_range & (issue_idx == IDX_W'(gi));
         assign free_sel[gi]  = push & (resp_idx == IDX_W'(gi));
         assign vld_next[gi]  = alloc_sel[gi] | (vld_reg[gi] & ~free_sel[gi]);

         always_ff @(posedge clk) begin
            if (rst) begin
               addr_reg[gi] <= '0;
               size_reg[gi] <= '0;
            end else if (alloc_sel[gi]) begin
               addr_reg[gi] <= issue_addr_lo;
               size_reg[gi] <= issue_size;
            end
         end
      end
   endgenerate

   always_comb begin
      raw      = {noc_resp_data_1, noc_resp_data_0};
      shifted  = raw >> {old_addr, 3'b000};
      aligned  = raw;
      bad_size = 1'b0;
      case (old_size)
         3'b001:  aligned = {120'd0, shifted[7:0]};
         3'b010:  aligned = {112'd0, shifted[15:0]};
         3'b011:  aligned = {96'd0, shifted[31:0]};
         3'b100:  aligned = {64'd0, shifted[63:0]};
         3'b101:  aligned = raw;
         default: bad_size = 1'b1;
      endcase
   end

   always_comb begin
      cnt_next = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) cnt_next = cnt_next + CNT_W'(vld_reg[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         vld_reg <= vld_next;
         if ((issue_fire & ~issue_in_range) | (|(alloc_sel & vld_reg & ~free_sel)) |
             (accept & ~resp_hit) | (push & bad_size))
            err_reg <= 1'b1;
      end
   end

   // Two-entry queue: head drives the outputs directly, tail holds the overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_vld_reg  <= 1'b0;
         head_id_reg   <= '0;
         head_data_reg <= '0;
         tail_vld_reg  <= 1'b0;
         tail_id_reg   <= '0;
         tail_data_reg <= '0;
      end else if (push) begin
         if (pop && tail_vld_reg) begin
            head_id_reg   <= tail_id_reg;
            head_data_reg <= tail_data_reg;
            tail_id_reg   <= noc_resp_mshrid;
            tail_data_reg <= aligned;
         end else if (pop || !head_vld_reg) begin
            head_vld_reg  <= 1'b1;
            head_id_reg   <= noc_resp_mshrid;
            head_data_reg <= aligned;
         end else begin
            tail_vld_reg  <= 1'b1;
            tail_id_reg   <= noc_resp_mshrid;
            tail_data_reg <= aligned;
         end
      end else if (pop) begin
         head_vld_reg  <= tail_vld_reg;
         head_id_reg   <= tail_id_reg;
         head_data_reg <= tail_data_reg;
         tail_vld_reg  <= 1'b0;
      end
   end

   assign ld_resp_valid  = head_vld_reg;
   assign ld_resp_mshrid = head_id_reg;
   assign ld_resp_data   = head_data_reg;
   assign outstanding    = cnt_next;
   assign err            = err_reg;
endmodule

// File: tb/tb_noc_resp_to_ld_adapter.sv
// Directed bench for noc_resp_to_ld_adapter: hits, size sweep, backpressure,
// same-cycle alloc/free, reset mid-flight and error cases.
module tb_noc_resp_to_ld_adapter;
   logic         clk = 1'b0;
   logic         rst;
   logic         issue_fire;
   logic [7:0]   issue_mshrid;
   logic [3:0]   issue_addr_lo;
   logic [2:0]   issue_size;
   logic         noc_resp_valid;
   logic         noc_resp_ready;
   logic [7:0]   noc_resp_mshrid;
   logic [63:0]  noc_resp_data_0;
   logic [63:0]  noc_resp_data_1;
   logic         ld_resp_valid;
   logic         ld_resp_ready;
   logic [7:0]   ld_resp_mshrid;
   logic [127:0] ld_resp_data;
   logic [3:0]   outstanding;
   logic         err;

   int checks = 0;
   int errors = 0;

   noc_resp_to_ld_adapter dut (
      .clk(clk), .rst(rst),
      .issue_fire(issue_fire), .issue_mshrid(issue_mshrid),
      .issue_addr_lo(issue_addr_lo), .issue_size(issue_size),
      .noc_resp_valid(noc_resp_valid), .noc_resp_ready(noc_resp_ready),
      .noc_resp_mshrid(noc_resp_mshrid),
      .noc_resp_data_0(noc_resp_data_0), .noc_resp_data_1(noc_resp_data_1),
      .ld_resp_valid(ld_resp_valid), .ld_resp_ready(ld_resp_ready),
      .ld_resp_mshrid(ld_resp_mshrid), .ld_resp_data(ld_resp_data),
      .outstanding(outstanding), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] id, input logic [3:0] a, input logic [2:0] s);
      issue_fire = 1'b1; issue_mshrid = id; issue_addr_lo = a; issue_size = s;
      tick();
      issue_fire = 1'b0;
   endtask

   task automatic respond(input logic [7:0] id, input logic [63:0] d0, input logic [63:0] d1);
      noc_resp_valid = 1'b1; noc_resp_mshrid = id;
      noc_resp_data_0 = d0; noc_resp_data_1 = d1;
      tick();
      noc_resp_valid = 1'b0;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   localparam logic [63:0] SD0 = 64'h0706050403020100;
   localparam logic [63:0] SD1 = 64'hF0E0D0C0B0A09080;

   initial begin
      rst = 1'b1; issue_fire = 1'b0; issue_mshrid = '0; issue_addr_lo = '0; issue_size = '0;
      noc_resp_valid = 1'b0; noc_resp_mshrid = '0; noc_resp_data_0 = '0; noc_resp_data_1 = '0;
      ld_resp_ready = 1'b1;
      tick();
      chk("ready_in_reset", noc_resp_ready, 1);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_ld_valid", ld_resp_valid, 0);
      chk("rst_ld_mshrid", ld_resp_mshrid, 0);
      chk("rst_ld_data", ld_resp_data, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", noc_resp_ready, 1);

      // Basic hit
      issue(8'd3, 4'd4, 3'b011);
      chk("basic_outstanding_1", outstanding, 1);
      respond(8'd3, 64'h8877665544332211, 64'h0);
      chk("basic_valid", ld_resp_valid, 1);
      chk("basic_mshrid", ld_resp_mshrid, 3);
      chk("basic_data", ld_resp_data, 128'h88776655);
      chk("basic_outstanding_0", outstanding, 0);
      tick();
      chk("basic_popped", ld_resp_valid, 0);

      // Size sweep at addr_lo=8
      issue(8'd0, 4'd8, 3'b001);
      issue(8'd1, 4'd8, 3'b010);
      issue(8'd2, 4'd8, 3'b100);
      issue(8'd3, 4'd8, 3'b101);
      chk("sweep_outstanding_4", outstanding, 4);
      respond(8'd0, SD0, SD1);
      chk("sweep_1byte", ld_resp_data, 128'h80);
      respond(8'd1, SD0, SD1);
      chk("sweep_2byte", ld_resp_data, 128'h9080);
      respond(8'd2, SD0, SD1);
      chk("sweep_8byte", ld_resp_data, 128'hF0E0D0C0B0A09080);
      respond(8'd3, SD0, SD1);
      chk("sweep_16byte", ld_resp_data, 128'hF0E0D0C0B0A09080_0706050403020100);
      chk("sweep_16byte_id", ld_resp_mshrid, 3);
      tick();
      chk("sweep_drained", ld_resp_valid, 0);
      chk("sweep_outstanding_0", outstanding, 0);

      // Backpressure
      ld_resp_ready = 1'b0;
      issue(8'd4, 4'd0, 3'b011);
      issue(8'd5, 4'd0, 3'b011);
      issue(8'd6, 4'd0, 3'b011);
      respond(8'd4, 64'hFFFFFFFF_C0DE0004, 64'h0);
      respond(8'd5, 64'hFFFFFFFF_C0DE0005, 64'h0);
      chk("bp_ready_low", noc_resp_ready, 0);
      noc_resp_valid = 1'b1; noc_resp_mshrid = 8'd6; noc_resp_data_0 = 64'hFFFFFFFF_C0DE0006;
      tick();
      chk("bp_head_id_stall", ld_resp_mshrid, 4);
      chk("bp_head_data_stall", ld_resp_data, 128'hC0DE0004);
      chk("bp_outstanding_1", outstanding, 1);
      tick();
      chk("bp_head_stable", ld_resp_data, 128'hC0DE0004);
      chk("bp_still_blocked", noc_resp_ready, 0);
      ld_resp_ready = 1'b1;
      #1;
      chk("bp_ready_with_pop", noc_resp_ready, 1);
      tick();
      noc_resp_valid = 1'b0;
      chk("bp_second_id", ld_resp_mshrid, 5);
      chk("bp_second_data", ld_resp_data, 128'hC0DE0005);
      tick();
      chk("bp_third_id", ld_resp_mshrid, 6);
      chk("bp_third_data", ld_resp_data, 128'hC0DE0006);
      tick();
      chk("bp_drained", ld_resp_valid, 0);
      chk("bp_outstanding_0", outstanding, 0);

      // Same-cycle alloc/free on entry 2
      issue(8'd2, 4'd0, 3'b001);
      issue_fire = 1'b1; issue_mshrid = 8'd2; issue_addr_lo = 4'd0; issue_size = 3'b100;
      respond(8'd2, 64'h1122334455667788, 64'h0);
      issue_fire = 1'b0;
      chk("same_old_mask", ld_resp_data, 128'h88);
      chk("same_outstanding", outstanding, 1);
      chk("same_err", err, 0);
      respond(8'd2, 64'h1122334455667788, 64'h0);
      chk("same_new_size", ld_resp_data, 128'h1122334455667788);
      chk("same_freed", outstanding, 0);
      chk("same_err_after", err, 0);
      tick();

      // Reset mid-flight
      ld_resp_ready = 1'b0;
      for (int i = 0; i < 6; i++) issue(8'(i), 4'd0, 3'b100);
      respond(8'd0, 64'hA0, 64'h0);
      respond(8'd1, 64'hA1, 64'h0);
      chk("mid_outstanding_4", outstanding, 4);
      chk("mid_queue_full", noc_resp_ready, 0);
      rst = 1'b1;
      #1;
      chk("mid_ready_in_rst", noc_resp_ready, 1);
      tick();
      rst = 1'b0;
      chk("mid_ld_valid", ld_resp_valid, 0);
      chk("mid_outstanding_0", outstanding, 0);
      chk("mid_err", err, 0);
      ld_resp_ready = 1'b1;

      // Errors
      issue(8'd9, 4'd0, 3'b011);
      chk("err_issue_oor", err, 1);
      chk("err_issue_oor_cnt", outstanding, 0);
      reset_pulse();
      chk("err_cleared", err, 0);
      respond(8'd5, 64'h55, 64'h0);
      chk("err_miss_no_valid", ld_resp_valid, 0);
      chk("err_miss", err, 1);
      chk("err_miss_cnt", outstanding, 0);
      tick();
      chk("err_sticky", err, 1);
      reset_pulse();
      issue(8'd1, 4'd0, 3'b011);
      chk("err_realloc_pre", err, 0);
      issue(8'd1, 4'd0, 3'b011);
      chk("err_realloc", err, 1);
      chk("err_realloc_cnt", outstanding, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
